// File: rtl/wb_initiator.sv
// Purpose: single-transaction Wishbone classic initiator; turns one local request into one bus
//          cycle and returns the result on a held response channel, with an optional ack timeout.
// Latency: request accepted at edge 0, earliest ack sampled at edge 1, respValid high after edge 1.
// Backpressure: reqReady is high only in IDLE; a response is held until respReady, and the next
//               request is taken no earlier than the edge after returning to IDLE.
//
// Ports:
//   clk, rst                     clock (rising edge) and asynchronous active-low reset
//   reqValid/reqReady            request handshake; reqWe, reqAdr, reqDat carry the request
//   respValid/respReady          response handshake; respDat is the captured data, respErr flags timeout
//   wbCycO, wbStbO, wbWeO,
//   wbAdrO, wbDatO               Wishbone initiator outputs
//   wbDatI, wbAckI               Wishbone responder inputs
module wb_initiator #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reqValid,
   output logic                  reqReady,
   input  logic                  reqWe,
   input  logic [ADDR_WIDTH-1:0] reqAdr,
   input  logic [DATA_WIDTH-1:0] reqDat,
   output logic                  respValid,
   input  logic                  respReady,
   output logic [DATA_WIDTH-1:0] respDat,
   output logic                  respErr,
   output logic                  wbCycO,
   output logic                  wbStbO,
   output logic                  wbWeO,
   output logic [ADDR_WIDTH-1:0] wbAdrO,
   output logic [DATA_WIDTH-1:0] wbDatO,
   input  logic [DATA_WIDTH-1:0] wbDatI,
   input  logic                  wbAckI
);

   // A zero TIMEOUT would give a zero-width counter; keep one bit that simply never matters.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           stateNext;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             timeoutHit;

   // cnt holds the number of ack-less sampling edges already spent in BUS, so the
   // edge on which it equals TIMEOUT-1 is the TIMEOUT-th one.
   assign timeoutHit = (TIMEOUT != 0) && (cnt == CNT_LAST);
   assign accept     = (state == IDLE) && reqValid;

   // Cycle/strobe and the handshakes are decoded straight from the state register so an
   // asynchronous reset drops them at once, without waiting for an edge.
   assign reqReady  = (state == IDLE);
   assign wbCycO    = (state == BUS);
   assign wbStbO    = (state == BUS);
   assign respValid = (state == RESP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (reqValid) stateNext = BUS;
         BUS:     if (wbAckI || timeoutHit) stateNext = RESP;
         RESP:    if (respReady) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wbWeO   <= 1'b0;
         wbAdrO  <= '0;
         wbDatO  <= '0;
         respDat <= '0;
         respErr <= 1'b0;
         cnt     <= '0;
      end else begin
         if (accept) begin
            wbWeO  <= reqWe;
            wbAdrO <= reqAdr;
            wbDatO <= reqDat;
            cnt    <= '0;
         end
         if (state == BUS) begin
            // Ack takes priority over a timeout landing on the same edge.
            if (wbAckI) begin
               respDat <= wbDatI;
               respErr <= 1'b0;
            end else if (timeoutHit) begin
               respDat <= '0;
               respErr <= 1'b1;
            end else if ((TIMEOUT != 0) && (cnt != '1)) begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_initiator.sv
module tb_wb_initiator;

   logic        clk;
   logic        rst;
   logic        reqValid;
   logic        reqReady;
   logic        reqWe;
   logic [3:0]  reqAdr;
   logic [15:0] reqDat;
   logic        respValid;
   logic        respReady;
   logic [15:0] respDat;
   logic        respErr;
   logic        wbCycO;
   logic        wbStbO;
   logic        wbWeO;
   logic [3:0]  wbAdrO;
   logic [15:0] wbDatO;
   logic [15:0] wbDatI;
   logic        wbAckI;

   int checks = 0;
   int errors = 0;

   wb_initiator #(
      .DATA_WIDTH(16),
      .ADDR_WIDTH(4),
      .TIMEOUT   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .reqValid (reqValid),
      .reqReady (reqReady),
      .reqWe    (reqWe),
      .reqAdr   (reqAdr),
      .reqDat   (reqDat),
      .respValid(respValid),
      .respReady(respReady),
      .respDat  (respDat),
      .respErr  (respErr),
      .wbCycO   (wbCycO),
      .wbStbO   (wbStbO),
      .wbWeO    (wbWeO),
      .wbAdrO   (wbAdrO),
      .wbDatO   (wbDatO),
      .wbDatI   (wbDatI),
      .wbAckI   (wbAckI)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic we, input logic [3:0] adr, input logic [15:0] dat);
      reqValid = 1'b1;
      reqWe    = we;
      reqAdr   = adr;
      reqDat   = dat;
      tick();
      reqValid = 1'b0;
   endtask

   task automatic drainResp();
      respReady = 1'b1;
      tick();
      respReady = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqAdr = '0; reqDat = '0;
      respReady = 1'b0; wbDatI = '0; wbAckI = 1'b0;
      #3;
      check("rst_reqReady", reqReady, 1);
      check("rst_cyc", wbCycO, 0);
      check("rst_stb", wbStbO, 0);
      check("rst_respValid", respValid, 0);
      check("rst_respDat", respDat, 16'h0000);
      check("rst_adr", wbAdrO, 0);
      #4 rst = 1'b1;
      tick();

      // Write, ack on the first sampling edge; responder returns data even for a write.
      request(1'b1, 4'h1, 16'h00FF);
      check("w_cyc", wbCycO, 1);
      check("w_stb", wbStbO, 1);
      check("w_adr", wbAdrO, 4'h1);
      check("w_dat", wbDatO, 16'h00FF);
      check("w_we", wbWeO, 1);
      check("w_reqReady", reqReady, 0);
      wbAckI = 1'b1; wbDatI = 16'h1234;
      tick();
      wbAckI = 1'b0;
      check("w_cyc_drop", wbCycO, 0);
      check("w_respValid", respValid, 1);
      check("w_respErr", respErr, 0);
      check("w_respDat", respDat, 16'h1234);
      drainResp();
      check("w_idle_respValid", respValid, 0);
      check("w_idle_reqReady", reqReady, 1);

      // Stray ack in IDLE must not start anything or touch respDat.
      wbAckI = 1'b1; wbDatI = 16'hFFFF;
      tick();
      wbAckI = 1'b0;
      check("stray_idle_reqReady", reqReady, 1);
      check("stray_idle_cyc", wbCycO, 0);
      check("stray_idle_respDat", respDat, 16'h1234);

      // Read, ack on the third sampling edge.
      request(1'b0, 4'h0, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         check("r_stb_held", wbStbO, 1);
         check("r_adr_held", wbAdrO, 4'h0);
         check("r_we_held", wbWeO, 0);
         if (i == 2) begin
            wbAckI = 1'b1; wbDatI = 16'hA5C3;
         end
         tick();
      end
      wbAckI = 1'b0;
      check("r_stb_drop", wbStbO, 0);
      check("r_respValid", respValid, 1);
      check("r_respDat", respDat, 16'hA5C3);
      check("r_respErr", respErr, 0);
      drainResp();

      // Timeout with no ack: stb high for exactly 4 sampling edges.
      request(1'b0, 4'h7, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         check("to_stb_held", wbStbO, 1);
         tick();
      end
      check("to_stb_drop", wbStbO, 0);
      check("to_respValid", respValid, 1);
      check("to_respErr", respErr, 1);
      check("to_respDat", respDat, 16'h0000);
      drainResp();

      // Ack on the 4th sampling edge beats the timeout.
      request(1'b0, 4'h7, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            wbAckI = 1'b1; wbDatI = 16'h5A5A;
         end
         tick();
      end
      wbAckI = 1'b0;
      check("tack_respValid", respValid, 1);
      check("tack_respErr", respErr, 0);
      check("tack_respDat", respDat, 16'h5A5A);
      drainResp();

      // Response backpressure with a new request waiting; stray ack during RESP.
      request(1'b0, 4'h5, 16'h0000);
      wbAckI = 1'b1; wbDatI = 16'h0F0F;
      tick();
      wbAckI = 1'b0;
      reqValid = 1'b1; reqWe = 1'b1; reqAdr = 4'h3; reqDat = 16'hBEEF;
      for (int i = 0; i < 5; i++) begin
         check("bp_respValid", respValid, 1);
         check("bp_respDat", respDat, 16'h0F0F);
         check("bp_reqReady", reqReady, 0);
         check("bp_cyc", wbCycO, 0);
         if (i == 2) begin
            wbAckI = 1'b1; wbDatI = 16'hFFFF;
         end else begin
            wbAckI = 1'b0;
         end
         tick();
      end
      wbAckI = 1'b0;
      respReady = 1'b1;
      tick();
      respReady = 1'b0;
      check("bp_back_idle", reqReady, 1);
      check("bp_no_cyc_yet", wbCycO, 0);
      tick();
      reqValid = 1'b0;
      check("bp_accept_cyc", wbCycO, 1);
      check("bp_accept_adr", wbAdrO, 4'h3);
      check("bp_accept_dat", wbDatO, 16'hBEEF);
      wbAckI = 1'b1; wbDatI = 16'h0001;
      tick();
      wbAckI = 1'b0;
      drainResp();

      // Asynchronous reset in the middle of a bus cycle.
      request(1'b1, 4'h9, 16'h1111);
      check("rm_stb_before", wbStbO, 1);
      #2 rst = 1'b0;
      #1;
      check("rm_cyc_drop", wbCycO, 0);
      check("rm_stb_drop", wbStbO, 0);
      check("rm_reqReady", reqReady, 1);
      check("rm_respDat", respDat, 16'h0000);
      #1 rst = 1'b1;
      tick();
      check("rm_after_reqReady", reqReady, 1);
      request(1'b1, 4'h2, 16'hCAFE);
      check("rm_w_adr", wbAdrO, 4'h2);
      check("rm_w_dat", wbDatO, 16'hCAFE);
      wbAckI = 1'b1; wbDatI = 16'h7777;
      tick();
      wbAckI = 1'b0;
      check("rm_w_respValid", respValid, 1);
      check("rm_w_respDat", respDat, 16'h7777);
      check("rm_w_respErr", respErr, 0);
      drainResp();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
